// File: rtl/dbus_interface.sv
// Data-side bus unit: runs one memory-stage load/store as a single Wishbone-classic cycle.
// Optional bus watchdog is enabled by defining DBUS_TIMEOUT_EN.
module dbus_interface #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_store_data,
  input  logic [1:0]  mem_size,
  input  logic        mem_signed,
  input  logic        mem_load,
  input  logic        mem_store,
  input  logic        pipeline_stall,
  output logic [31:0] mem_load_data,
  output logic        mem_busy,
  output logic        mem_fault,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [29:0] wb_adr_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  output logic [1:0]  dbg_state
);

  // Handshake: the memory stage holds its request until mem_busy drops (DONE); the
  // request is consumed when DONE is left, i.e. at the first edge with pipeline_stall low.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        w_req;
  logic        w_busy;
  logic        w_timeout;
  logic        w_end;
  logic        w_fault;
  logic [3:0]  w_sel;
  logic [31:0] w_wdat;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_fmt;

  logic        r_cyc;
  logic        r_we;
  logic [29:0] r_adr;
  logic [3:0]  r_sel;
  logic [31:0] r_dat;
  logic [1:0]  r_size;
  logic        r_signed;
  logic [1:0]  r_off;
  logic [31:0] r_load_data;
  logic        r_fault;

  assign w_req   = mem_load | mem_store;
  assign w_end   = wb_ack_i | wb_err_i | w_timeout;
  assign w_fault = wb_err_i | w_timeout;

  always_comb begin
    w_sel  = 4'b1111;
    w_wdat = mem_store_data;
    case (mem_size)
      2'b00: begin
        w_sel  = 4'b0001 << mem_address[1:0];
        w_wdat = {4{mem_store_data[7:0]}};
      end
      2'b01: begin
        w_sel  = mem_address[1] ? 4'b1100 : 4'b0011;
        w_wdat = {2{mem_store_data[15:0]}};
      end
      default: ;
    endcase
  end

  // Load formatting uses the lane offset captured at request time.
  assign w_byte = wb_dat_i[{r_off, 3'b000} +: 8];
  assign w_half = r_off[1] ? wb_dat_i[31:16] : wb_dat_i[15:0];

  always_comb begin
    w_fmt = wb_dat_i;
    case (r_size)
      2'b00:   w_fmt = {{24{r_signed & w_byte[7]}}, w_byte};
      2'b01:   w_fmt = {{16{r_signed & w_half[15]}}, w_half};
      default: ;
    endcase
  end

`ifdef DBUS_TIMEOUT_EN
  logic [31:0] r_wdog;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdog <= '0;
    end else if (r_state != S_BUS) begin
      r_wdog <= '0;
    end else if (!wb_ack_i && !wb_err_i) begin
      r_wdog <= r_wdog + 32'd1;
    end
  end

  assign w_timeout = (r_state == S_BUS) && !wb_ack_i && !wb_err_i &&
                     (r_wdog == TIMEOUT_CYCLES - 32'd1);
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    w_busy = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy = w_req;
        if (w_req) w_next = S_BUS;
      end
      S_BUS: begin
        w_busy = 1'b1;
        if (w_end) w_next = S_DONE;
      end
      S_DONE: begin
        if (!pipeline_stall) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cyc       <= 1'b0;
      r_we        <= 1'b0;
      r_adr       <= '0;
      r_sel       <= '0;
      r_dat       <= '0;
      r_size      <= '0;
      r_signed    <= 1'b0;
      r_off       <= '0;
      r_load_data <= '0;
      r_fault     <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_cyc    <= 1'b1;
            r_we     <= mem_store & ~mem_load;
            r_adr    <= mem_address[31:2];
            r_sel    <= w_sel;
            r_dat    <= w_wdat;
            r_size   <= mem_size;
            r_signed <= mem_signed;
            r_off    <= mem_address[1:0];
          end
        end
        S_BUS: begin
          if (w_end) begin
            r_cyc   <= 1'b0;
            r_fault <= w_fault;
            if (!r_we && wb_ack_i && !wb_err_i) r_load_data <= w_fmt;
          end
        end
        S_DONE: begin
          if (!pipeline_stall) r_fault <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign mem_busy      = w_busy;
  assign mem_fault     = r_fault;
  assign mem_load_data = r_load_data;
  assign wb_cyc_o      = r_cyc;
  assign wb_stb_o      = r_cyc;
  assign wb_we_o       = r_we;
  assign wb_adr_o      = r_adr;
  assign wb_sel_o      = r_sel;
  assign wb_dat_o      = r_dat;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_dbus_interface.sv
// Self-checking bench for dbus_interface: directed plan cases plus randomized accesses
// compared against a byte-lane reference model.
module tb_dbus_interface;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] mem_address = '0;
  logic [31:0] mem_store_data = '0;
  logic [1:0]  mem_size = '0;
  logic        mem_signed = 1'b0;
  logic        mem_load = 1'b0;
  logic        mem_store = 1'b0;
  logic        pipeline_stall = 1'b0;
  logic [31:0] mem_load_data;
  logic        mem_busy;
  logic        mem_fault;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [29:0] wb_adr_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i = '0;
  logic        wb_ack_i = 1'b0;
  logic        wb_err_i = 1'b0;
  logic [1:0]  dbg_state;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_ld = '0;

  dbus_interface #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .mem_address(mem_address), .mem_store_data(mem_store_data),
    .mem_size(mem_size), .mem_signed(mem_signed), .mem_load(mem_load), .mem_store(mem_store),
    .pipeline_stall(pipeline_stall), .mem_load_data(mem_load_data), .mem_busy(mem_busy),
    .mem_fault(mem_fault), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Reference model: lane arithmetic on the byte address.
  function automatic int m_nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic int m_off(input logic [31:0] a, input logic [1:0] sz);
    if (sz == 2'b00) return int'(a % 4);
    if (sz == 2'b01) return int'(a % 4) / 2 * 2;
    return 0;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] rd, input logic [31:0] a,
                                         input logic [1:0] sz, input logic sg);
    longint unsigned v;
    int nb;
    nb = m_nbytes(sz);
    v = (longint'(rd) >> (8 * m_off(a, sz))) & ((64'd1 << (8 * nb)) - 64'd1);
    if (sg && nb < 4 && ((v >> (8 * nb - 1)) & 64'd1) == 64'd1) v = v - (64'd1 << (8 * nb));
    return v[31:0];
  endfunction

  function automatic logic [3:0] m_sel(input logic [31:0] a, input logic [1:0] sz);
    int s;
    s = ((1 << m_nbytes(sz)) - 1) << m_off(a, sz);
    return s[3:0];
  endfunction

  function automatic logic [31:0] m_wdat(input logic [31:0] wd, input logic [1:0] sz);
    logic [31:0] o;
    for (int i = 0; i < 4; i++) o[8*i +: 8] = wd[8*(i % m_nbytes(sz)) +: 8];
    return o;
  endfunction

  // Driver + bus responder: runs one access, answering in cycle ack_cyc (request in cycle 0),
  // then holds pipeline_stall for stall_n DONE cycles. ack_cyc < 0 means never answer.
  task automatic do_access(
    input logic ld, input logic st, input logic [31:0] addr, input logic [31:0] wd,
    input logic [1:0] sz, input logic sg, input int ack_cyc, input logic err, input logic both,
    input logic [31:0] rd, input int stall_n,
    output int busy_n, output int stb_rise, output int stb_n, output int done_n,
    output logic stable_bus, output logic stable_done, output logic stb_c0, output logic timed_out,
    output logic [3:0] o_sel, output logic [29:0] o_adr, output logic [31:0] o_dat,
    output logic o_we, output logic o_fault, output logic [31:0] o_ld);
    logic prev_stb, seen_busy, in_done, finished;
    int c;
    mem_address = addr; mem_store_data = wd; mem_size = sz; mem_signed = sg;
    mem_load = ld; mem_store = st; wb_dat_i = rd;
    wb_ack_i = 1'b0; wb_err_i = 1'b0; pipeline_stall = 1'b0;
    busy_n = 0; stb_rise = 0; stb_n = 0; done_n = 0;
    stable_bus = 1'b1; stable_done = 1'b1; stb_c0 = 1'b0;
    o_sel = '0; o_adr = '0; o_dat = '0; o_we = 1'b0; o_fault = 1'b0; o_ld = '0;
    prev_stb = 1'b0; seen_busy = 1'b0; finished = 1'b0; c = 0;
    while (!finished && c < 300) begin
      @(negedge clk);
      if (mem_busy) busy_n++;
      if (wb_stb_o) begin
        stb_n++;
        if (!prev_stb) stb_rise++;
        if (c == 0) stb_c0 = 1'b1;
        if (stb_n == 1) begin
          o_sel = wb_sel_o; o_adr = wb_adr_o; o_dat = wb_dat_o; o_we = wb_we_o;
        end else if (wb_sel_o !== o_sel || wb_adr_o !== o_adr || wb_dat_o !== o_dat ||
                     wb_we_o !== o_we || !wb_cyc_o) begin
          stable_bus = 1'b0;
        end
      end
      prev_stb = wb_stb_o;
      in_done = seen_busy && !mem_busy;
      seen_busy = seen_busy | mem_busy;
      if (in_done) begin
        done_n++;
        if (done_n == 1) begin
          o_fault = mem_fault; o_ld = mem_load_data;
        end else if (mem_fault !== o_fault || mem_load_data !== o_ld || wb_stb_o) begin
          stable_done = 1'b0;
        end
      end
      wb_err_i = (c == ack_cyc) && err;
      wb_ack_i = (c == ack_cyc) && (!err || both);
      pipeline_stall = in_done && (done_n <= stall_n);
      if (in_done && !pipeline_stall) finished = 1'b1;
      c++;
    end
    @(posedge clk);
    #1;
    mem_load = 1'b0; mem_store = 1'b0; wb_ack_i = 1'b0; wb_err_i = 1'b0; pipeline_stall = 1'b0;
    timed_out = !finished;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++; if (wb_cyc_o !== 1'b0) begin failures++; $display("FAIL reset_cyc got=%b exp=0", wb_cyc_o); end
    checks++; if (wb_stb_o !== 1'b0) begin failures++; $display("FAIL reset_stb got=%b exp=0", wb_stb_o); end
    checks++; if (wb_we_o !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", wb_we_o); end
    checks++; if (wb_adr_o !== 30'd0) begin failures++; $display("FAIL reset_adr got=%h exp=0", wb_adr_o); end
    checks++; if (wb_sel_o !== 4'd0) begin failures++; $display("FAIL reset_sel got=%h exp=0", wb_sel_o); end
    checks++; if (wb_dat_o !== 32'd0) begin failures++; $display("FAIL reset_dat got=%h exp=0", wb_dat_o); end
    checks++; if (mem_load_data !== 32'd0) begin failures++; $display("FAIL reset_ld got=%h exp=0", mem_load_data); end
    checks++; if (mem_fault !== 1'b0) begin failures++; $display("FAIL reset_fault got=%b exp=0", mem_fault); end
    checks++; if (mem_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", mem_busy); end
    exp_ld = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_plan();
    int bn, sr, sn, dn;
    logic sb, sd, s0, to, we, flt;
    logic [3:0] sel; logic [29:0] adr; logic [31:0] dat, ld;
    // LB signed at 0x103
    do_access(1, 0, 32'h103, 32'h0, 2'b00, 1, 1, 0, 0, 32'h80FF_0000, 0,
              bn, sr, sn, dn, sb, sd, s0, to, sel, adr, dat, we, flt, ld);
    checks++; if (to) begin failures++; $display("FAIL lb_timeout got=1 exp=0"); end
    checks++; if (sel !== 4'b1000) begin failures++; $display("FAIL lb_sel got=%b exp=1000", sel); end
    checks++; if (ld !== 32'hFFFF_FF80) begin failures++; $display("FAIL lb_data got=%h exp=ffffff80", ld); end
    checks++; if (bn != 2) begin failures++; $display("FAIL lb_busy got=%0d exp=2", bn); end
    // LHU at 0x102
    do_access(1, 0, 32'h102, 32'h0, 2'b01, 0, 1, 0, 0, 32'hBEEF_1234, 0,
              bn, sr, sn, dn, sb, sd, s0, to, sel, adr, dat, we, flt, ld);
    checks++; if (sel !== 4'b1100) begin failures++; $display("FAIL lhu_sel got=%b exp=1100", sel); end
    checks++; if (ld !== 32'h0000_BEEF) begin failures++; $display("FAIL lhu_data got=%h exp=0000beef", ld); end
    checks++; if (we !== 1'b0) begin failures++; $display("FAIL lhu_we got=%b exp=0", we); end
    // SB at 0x201
    do_access(0, 1, 32'h201, 32'h1234_56AB, 2'b00, 0, 1, 0, 0, 32'h5555_5555, 0,
              bn, sr, sn, dn, sb, sd, s0, to, sel, adr, dat, we, flt, ld);
    checks++; if (we !== 1'b1) begin failures++; $display("FAIL sb_we got=%b exp=1", we); end
    checks++; if (sel !== 4'b0010) begin failures++; $display("FAIL sb_sel got=%b exp=0010", sel); end
    checks++; if (dat !== 32'hABAB_ABAB) begin failures++; $display("FAIL sb_dat got=%h exp=abababab", dat); end
    checks++; if (adr !== 30'h80) begin failures++; $display("FAIL sb_adr got=%h exp=80", adr); end
    checks++; if (sn != 1) begin failures++; $display("FAIL sb_stb_cycles got=%0d exp=1", sn); end
    checks++; if (ld !== 32'h0000_BEEF) begin failures++; $display("FAIL sb_ld_kept got=%h exp=0000beef", ld); end
    // LW, ack in cycle 3, stall 2 cycles after ack
    do_access(1, 0, 32'h300, 32'h0, 2'b10, 0, 3, 0, 0, 32'hCAFE_F00D, 2,
              bn, sr, sn, dn, sb, sd, s0, to, sel, adr, dat, we, flt, ld);
    checks++; if (bn != 4) begin failures++; $display("FAIL lw_busy got=%0d exp=4", bn); end
    checks++; if (sr != 1) begin failures++; $display("FAIL lw_stb_rise got=%0d exp=1", sr); end
    checks++; if (dn != 3) begin failures++; $display("FAIL lw_done got=%0d exp=3", dn); end
    checks++; if (!sd) begin failures++; $display("FAIL lw_done_stable got=0 exp=1"); end
    checks++; if (!sb) begin failures++; $display("FAIL lw_bus_stable got=0 exp=1"); end
    checks++; if (ld !== 32'hCAFE_F00D) begin failures++; $display("FAIL lw_data got=%h exp=cafef00d", ld); end
    exp_ld = 32'hCAFE_F00D;
  endtask

  task automatic test_error();
    int bn, sr, sn, dn;
    logic sb, sd, s0, to, we, flt;
    logic [3:0] sel; logic [29:0] adr; logic [31:0] dat, ld;
    do_access(1, 0, 32'h44, 32'h0, 2'b10, 0, 2, 1, 0, 32'h1111_2222, 1,
              bn, sr, sn, dn, sb, sd, s0, to, sel, adr, dat, we, flt, ld);
    checks++; if (flt !== 1'b1) begin failures++; $display("FAIL err_fault got=%b exp=1", flt); end
    checks++; if (ld !== exp_ld) begin failures++; $display("FAIL err_ld_kept got=%h exp=%h", ld, exp_ld); end
    // ack and err together count as err
    do_access(1, 0, 32'h48, 32'h0, 2'b00, 1, 1, 1, 1, 32'h0000_00F0, 0,
              bn, sr, sn, dn, sb, sd, s0, to, sel, adr, dat, we, flt, ld);
    checks++; if (flt !== 1'b1) begin failures++; $display("FAIL ackerr_fault got=%b exp=1", flt); end
    checks++; if (ld !== exp_ld) begin failures++; $display("FAIL ackerr_ld got=%h exp=%h", ld, exp_ld); end
    @(negedge clk);
    checks++; if (mem_fault !== 1'b0) begin failures++; $display("FAIL fault_clear got=%b exp=0", mem_fault); end
    @(posedge clk); #1;
`ifdef DBUS_TIMEOUT_EN
    do_access(1, 0, 32'h4C, 32'h0, 2'b10, 0, -1, 0, 0, 32'h0, 0,
              bn, sr, sn, dn, sb, sd, s0, to, sel, adr, dat, we, flt, ld);
    checks++; if (to) begin failures++; $display("FAIL wdog_hang got=1 exp=0"); end
    checks++; if (sn != 4) begin failures++; $display("FAIL wdog_bus_cycles got=%0d exp=4", sn); end
    checks++; if (flt !== 1'b1) begin failures++; $display("FAIL wdog_fault got=%b exp=1", flt); end
    checks++; if (ld !== exp_ld) begin failures++; $display("FAIL wdog_ld got=%h exp=%h", ld, exp_ld); end
`endif
  endtask

  task automatic test_back_to_back();
    int bn, sr, sn, dn;
    logic sb, sd, s0, to, we, flt;
    logic [3:0] sel; logic [29:0] adr; logic [31:0] dat, ld;
    do_access(1, 0, 32'h10, 32'h0, 2'b10, 0, 1, 0, 0, 32'h0BAD_CAFE, 0,
              bn, sr, sn, dn, sb, sd, s0, to, sel, adr, dat, we, flt, ld);
    do_access(0, 1, 32'h12, 32'hAAAA_5A5A, 2'b01, 0, 1, 0, 0, 32'h0, 0,
              bn, sr, sn, dn, sb, sd, s0, to, sel, adr, dat, we, flt, ld);
    checks++; if (s0) begin failures++; $display("FAIL b2b_idle_gap got=stb_in_cycle0 exp=idle"); end
    checks++; if (bn != 2) begin failures++; $display("FAIL b2b_busy got=%0d exp=2", bn); end
    checks++; if (dat !== 32'h5A5A_5A5A) begin failures++; $display("FAIL b2b_dat got=%h exp=5a5a5a5a", dat); end
    checks++; if (ld !== 32'h0BAD_CAFE) begin failures++; $display("FAIL b2b_ld got=%h exp=0badcafe", ld); end
    exp_ld = 32'h0BAD_CAFE;
  endtask

  task automatic test_random();
    int bn, sr, sn, dn, k, stl;
    logic sb, sd, s0, to, we, flt, ld_r, st_r, sg, err, both;
    logic [3:0] sel; logic [29:0] adr; logic [31:0] dat, ld, a, wd, rd;
    logic [1:0] sz;
    for (int it = 0; it < 40; it++) begin
      ld_r = 1'($urandom_range(0, 1));
      st_r = ld_r ? ($urandom_range(0, 3) == 0) : 1'b1;
      sz = 2'($urandom_range(0, 2)); a = $urandom; wd = $urandom; rd = $urandom;
      sg = 1'($urandom_range(0, 1)); k = $urandom_range(1, 4); stl = $urandom_range(0, 3);
      err = ($urandom_range(0, 7) == 0); both = err && ($urandom_range(0, 1) == 1);
      do_access(ld_r, st_r, a, wd, sz, sg, k, err, both, rd, stl,
                bn, sr, sn, dn, sb, sd, s0, to, sel, adr, dat, we, flt, ld);
      if (ld_r && !err) exp_ld = m_load(rd, a, sz, sg);
      checks++; if (to) begin failures++; $display("FAIL rnd%0d_hang got=1 exp=0", it); end
      checks++; if (bn != k + 1) begin failures++; $display("FAIL rnd%0d_busy got=%0d exp=%0d", it, bn, k + 1); end
      checks++; if (sr != 1 || sn != k) begin failures++; $display("FAIL rnd%0d_stb got=%0d/%0d exp=1/%0d", it, sr, sn, k); end
      checks++; if (dn != stl + 1) begin failures++; $display("FAIL rnd%0d_done got=%0d exp=%0d", it, dn, stl + 1); end
      checks++; if (sel !== m_sel(a, sz)) begin failures++; $display("FAIL rnd%0d_sel got=%b exp=%b", it, sel, m_sel(a, sz)); end
      checks++; if (adr !== a[31:2]) begin failures++; $display("FAIL rnd%0d_adr got=%h exp=%h", it, adr, a[31:2]); end
      checks++; if (we !== !ld_r) begin failures++; $display("FAIL rnd%0d_we got=%b exp=%b", it, we, !ld_r); end
      if (!ld_r) begin
        checks++; if (dat !== m_wdat(wd, sz)) begin failures++; $display("FAIL rnd%0d_dat got=%h exp=%h", it, dat, m_wdat(wd, sz)); end
      end
      checks++; if (flt !== err) begin failures++; $display("FAIL rnd%0d_fault got=%b exp=%b", it, flt, err); end
      checks++; if (ld !== exp_ld) begin failures++; $display("FAIL rnd%0d_ld got=%h exp=%h", it, ld, exp_ld); end
      checks++; if (!sb || !sd || s0) begin failures++; $display("FAIL rnd%0d_stable got=%b%b%b exp=110", it, sb, sd, s0); end
    end
  endtask

  task automatic test_reset_mid_bus();
    mem_address = 32'h400; mem_size = 2'b10; mem_load = 1'b1; wb_ack_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (wb_stb_o !== 1'b1) begin failures++; $display("FAIL rst_pre_stb got=%b exp=1", wb_stb_o); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0) begin failures++; $display("FAIL rst_async got=%b%b exp=00", wb_cyc_o, wb_stb_o); end
    mem_load = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    checks++; if (mem_busy !== 1'b0) begin failures++; $display("FAIL rst_post_busy got=%b exp=0", mem_busy); end
    checks++; if (mem_load_data !== 32'd0 || mem_fault !== 1'b0) begin failures++; $display("FAIL rst_post_mem got=%h/%b exp=0/0", mem_load_data, mem_fault); end
    checks++; if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o} !== '0) begin failures++; $display("FAIL rst_post_wb got=%h/%h/%h exp=0", wb_adr_o, wb_sel_o, wb_dat_o); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_plan();
    test_error();
    test_back_to_back();
    test_random();
    test_reset_mid_bus();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
